// File: rtl/regmask_encoder_32_5_if.sv
// rtl/regmask_encoder_32_5_if.sv - mask load and register-ID output handshake bundle
interface regmask_encoder_32_5_if #(
    parameter int WIDTH = 32,
    parameter int IDW   = 5
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] Mask;
    logic             out_valid;
    logic             out_ready;
    logic [IDW-1:0]   RegId;
    logic             last;
    logic [IDW:0]     Count;
    logic             zero_mask;

    modport master (
        output load_valid, Mask, out_ready,
        input  load_ready, out_valid, RegId, last, Count, zero_mask
    );

    modport slave (
        input  load_valid, Mask, out_ready,
        output load_ready, out_valid, RegId, last, Count, zero_mask
    );
endinterface

// File: rtl/regmask_encoder_32_5.sv
// rtl/regmask_encoder_32_5.sv - serialise a register mask into register IDs, lowest first
module regmask_encoder_32_5 #(
    parameter int WIDTH = 32,
    parameter int IDW   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    regmask_encoder_32_5_if.slave  bus
);
    typedef enum logic {IDLE, DRAIN} state_t;

    state_t           state;
    logic [WIDTH-1:0] pending;
    logic             zero_mask_q;
    logic [IDW-1:0]   enc;
    logic [IDW:0]     cnt;
    logic             out_valid;
    logic             last;
    logic             out_fire;
    logic             load_ready;
    logic             load_fire;

    // Scan high to low so the lowest set bit wins; an empty mask encodes as 0.
    always_comb begin
        enc = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                enc = IDW'(i);
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + (IDW + 1)'(pending[i]);
        end
    end

    assign out_valid  = (state == DRAIN);
    assign last       = out_valid && (cnt == (IDW + 1)'(1));
    assign out_fire   = out_valid && bus.out_ready;
    assign load_ready = !flush && ((state == IDLE) || (out_fire && last));
    assign load_fire  = bus.load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= '0;
            zero_mask_q <= 1'b0;
        end else begin
            zero_mask_q <= 1'b0;
            if (flush) begin
                state   <= IDLE;
                pending <= '0;
            end else if (load_fire) begin
                // Also covers the final handshake of the previous mask: its bit is consumed here.
                pending     <= bus.Mask;
                state       <= (bus.Mask != '0) ? DRAIN : IDLE;
                zero_mask_q <= (bus.Mask == '0);
            end else if (out_fire) begin
                pending[enc] <= 1'b0;
                if (last) begin
                    state <= IDLE;
                end
            end
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.out_valid  = out_valid;
    assign bus.RegId      = enc;
    assign bus.last       = last;
    assign bus.Count      = cnt;
    assign bus.zero_mask  = zero_mask_q;
endmodule

// File: tb/tb_regmask_encoder_32_5.sv
// tb/tb_regmask_encoder_32_5.sv - table-driven bench for regmask_encoder_32_5
module tb_regmask_encoder_32_5;
    logic clk = 1'b0;
    logic rst;
    logic flush;

    regmask_encoder_32_5_if #(.WIDTH(32), .IDW(5)) bus ();

    regmask_encoder_32_5 #(.WIDTH(32), .IDW(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        lv;
        logic [31:0] m;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic [4:0]  id;
        logic        lst;
        logic [5:0]  cnt;
        logic        zm;
        logic        lr;
    } vec_t;

    vec_t vt[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic lv, input logic [31:0] m, input logic ordy, input logic fl,
                       input logic ov, input logic [4:0] id, input logic lst,
                       input logic [5:0] cnt, input logic zm, input logic lr);
        vec_t v;
        v.lv = lv; v.m = m; v.ordy = ordy; v.fl = fl;
        v.ov = ov; v.id = id; v.lst = lst; v.cnt = cnt; v.zm = zm; v.lr = lr;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ov, input logic [4:0] id, input logic lst,
                           input logic [5:0] cnt, input logic zm, input logic lr);
        chk({tag, " out_valid"},  int'(bus.out_valid),  int'(ov));
        chk({tag, " RegId"},      int'(bus.RegId),      int'(id));
        chk({tag, " last"},       int'(bus.last),       int'(lst));
        chk({tag, " Count"},      int'(bus.Count),      int'(cnt));
        chk({tag, " zero_mask"},  int'(bus.zero_mask),  int'(zm));
        chk({tag, " load_ready"}, int'(bus.load_ready), int'(lr));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        bus.load_valid = 1'b0; bus.Mask = '0; bus.out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;

        //   lv  mask          ordy fl   ov id  lst cnt zm lr
        add(1, 32'h0000_0001, 1, 0,   0, 0,  0,  0, 0, 1);
        add(0, 32'h0,         1, 0,   1, 0,  1,  1, 0, 1);
        add(0, 32'h0,         1, 0,   0, 0,  0,  0, 0, 1);
        add(1, 32'h8000_0011, 1, 0,   0, 0,  0,  0, 0, 1);
        add(0, 32'h0,         1, 0,   1, 0,  0,  3, 0, 0);
        add(0, 32'h0,         1, 0,   1, 4,  0,  2, 0, 0);
        add(0, 32'h0,         1, 0,   1, 31, 1,  1, 0, 1);
        add(1, 32'h0,         1, 0,   0, 0,  0,  0, 0, 1);
        add(0, 32'h0,         1, 0,   0, 0,  0,  0, 1, 1);
        add(0, 32'h0,         1, 0,   0, 0,  0,  0, 0, 1);
        add(1, 32'h0000_0006, 1, 0,   0, 0,  0,  0, 0, 1);
        add(0, 32'h0,         1, 0,   1, 1,  0,  2, 0, 0);
        add(1, 32'h0000_0100, 1, 0,   1, 2,  1,  1, 0, 1);
        add(0, 32'h0,         1, 0,   1, 8,  1,  1, 0, 1);
        add(0, 32'h0,         1, 0,   0, 0,  0,  0, 0, 1);
        add(1, 32'h0000_000A, 0, 0,   0, 0,  0,  0, 0, 1);
        add(0, 32'h0,         0, 0,   1, 1,  0,  2, 0, 0);
        add(0, 32'h0,         0, 0,   1, 1,  0,  2, 0, 0);
        add(0, 32'h0,         1, 0,   1, 1,  0,  2, 0, 0);
        add(0, 32'h0,         1, 0,   1, 3,  1,  1, 0, 1);
        add(1, 32'h0000_0001, 1, 0,   0, 0,  0,  0, 0, 1);
        add(1, 32'h0,         1, 0,   1, 0,  1,  1, 0, 1);
        add(0, 32'h0,         1, 0,   0, 0,  0,  0, 1, 1);
        add(1, 32'h0000_00F0, 1, 0,   0, 0,  0,  0, 0, 1);
        add(0, 32'h0,         1, 0,   1, 4,  0,  4, 0, 0);
        add(1, 32'h0000_00FF, 1, 1,   1, 5,  0,  3, 0, 0);
        add(0, 32'h0,         0, 0,   0, 0,  0,  0, 0, 1);
        add(1, 32'h0000_0003, 0, 1,   0, 0,  0,  0, 0, 0);
        add(0, 32'h0,         0, 0,   0, 0,  0,  0, 0, 1);
        add(1, 32'h8000_0000, 1, 0,   0, 0,  0,  0, 0, 1);
        add(0, 32'h0,         1, 0,   1, 31, 1,  1, 0, 1);
        add(0, 32'h0,         1, 0,   0, 0,  0,  0, 0, 1);

        foreach (vt[k]) begin
            bus.load_valid = vt[k].lv;
            bus.Mask       = vt[k].m;
            bus.out_ready  = vt[k].ordy;
            flush          = vt[k].fl;
            #1;
            chk_all($sformatf("vec%0d", k), vt[k].ov, vt[k].id, vt[k].lst,
                    vt[k].cnt, vt[k].zm, vt[k].lr);
            tick();
        end
        flush = 1'b0;

        // Full mask with out_ready toggling: each ID holds through its stall cycle.
        bus.load_valid = 1'b1; bus.Mask = 32'hFFFF_FFFF; bus.out_ready = 1'b0;
        tick();
        bus.load_valid = 1'b0; bus.Mask = '0;
        for (int i = 0; i < 32; i++) begin
            bus.out_ready = 1'b0;
            #1;
            chk_all($sformatf("full stall%0d", i), 1'b1, 5'(i), (i == 31),
                    6'(32 - i), 1'b0, 1'b0);
            tick();
            bus.out_ready = 1'b1;
            #1;
            chk_all($sformatf("full go%0d", i), 1'b1, 5'(i), (i == 31),
                    6'(32 - i), 1'b0, (i == 31));
            tick();
        end
        bus.out_ready = 1'b0;
        #1;
        chk_all("full done", 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 1'b1);

        // Reset in the middle of draining 0xF0, after ID 4 has gone out.
        bus.load_valid = 1'b1; bus.Mask = 32'h0000_00F0;
        tick();
        bus.load_valid = 1'b0; bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        #1;
        chk_all("rst pre", 1'b1, 5'd5, 1'b0, 6'd3, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk_all("rst post", 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 1'b1);
        tick();
        #1;
        chk_all("rst idle", 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
